// File: rtl/dsq_pcpi_ctrl_pkg.sv
// Shared encodings for the dsq PCPI controller: opcode/funct7 match values,
// funct3 operation codes and controller FSM states.
package dsq_pcpi_ctrl_pkg;

    localparam logic [6:0] DSQ_OPC    = 7'b0001011;
    localparam logic [6:0] DSQ_FUNCT7 = 7'b0000001;

    typedef enum logic [2:0] {
        F3_DSQ     = 3'b000,
        F3_DSQ_ACC = 3'b001,
        F3_ACC_CLR = 3'b010,
        F3_ACC_RD  = 3'b011,
        F3_ACC_WR  = 3'b100
    } dsq_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2,
        S_GUARD = 2'd3
    } dsq_state_e;

    // Only DSQ and DSQ.ACC need the shared datapath.
    function automatic logic op_uses_dp(input dsq_op_e op);
        return (op == F3_DSQ) || (op == F3_DSQ_ACC);
    endfunction

endpackage

// File: rtl/dsq_pcpi_ctrl_if.sv
// Core-side PCPI bundle and controller-to-datapath dsq bundle.
// The core / controller is always the master of its respective bundle.
interface dsq_pcpi_if;
    logic        pcpi_valid;
    logic [31:0] pcpi_instr;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_wait;
    logic        pcpi_ready;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;

    modport master (output pcpi_valid, pcpi_instr, pcpi_rs1, pcpi_rs2,
                    input  pcpi_wait, pcpi_ready, pcpi_wr, pcpi_rd);
    modport slave  (input  pcpi_valid, pcpi_instr, pcpi_rs1, pcpi_rs2,
                    output pcpi_wait, pcpi_ready, pcpi_wr, pcpi_rd);
endinterface

interface dsq_dp_if;
    logic        dsq_valid;
    logic [31:0] dsq_rs1;
    logic [31:0] dsq_rs2;
    logic        dsq_ready;
    logic [31:0] dsq_rd;

    modport master (output dsq_valid, dsq_rs1, dsq_rs2,
                    input  dsq_ready, dsq_rd);
    modport slave  (input  dsq_valid, dsq_rs1, dsq_rs2,
                    output dsq_ready, dsq_rd);
endinterface

// File: rtl/dsq_pcpi_ctrl_insn_decode.sv
// Combinational decode of custom-0 DSQ instructions: claim decision and op.
module dsq_insn_decode
    import dsq_pcpi_ctrl_pkg::*;
#(
    parameter logic [6:0] OPC    = DSQ_OPC,
    parameter logic [6:0] FUNCT7 = DSQ_FUNCT7
) (
    input  logic        i_valid,
    input  logic [31:0] i_instr,
    output logic        o_match,
    output dsq_op_e     o_op,
    output logic        o_use_dp
);
    logic w_f3_ok;
    logic w_unused;

    // Register-index fields are irrelevant: operands arrive on rs1/rs2.
    assign w_unused = ^{i_instr[24:15], i_instr[11:7]};

    assign o_op     = dsq_op_e'(i_instr[14:12]);
    assign w_f3_ok  = (i_instr[14:12] <= 3'b100);
    assign o_match  = i_valid && (i_instr[6:0] == OPC) &&
                      (i_instr[31:25] == FUNCT7) && w_f3_ok;
    assign o_use_dp = op_uses_dp(o_op);

endmodule

// File: rtl/dsq_pcpi_ctrl.sv
// PCPI controller sequencing one shared dsq datapath and owning the
// distance accumulator; results return over pcpi_rd/pcpi_wr.
module dsq_pcpi_ctrl
    import dsq_pcpi_ctrl_pkg::*;
#(
    parameter int         ACC_W   = 32,
    parameter int         TIMEOUT = 16,
    parameter logic [6:0] OPC     = DSQ_OPC,
    parameter logic [6:0] FUNCT7  = DSQ_FUNCT7
) (
    input  logic         clk,
    input  logic         reset,
    dsq_pcpi_if.slave    pcpi,
    dsq_dp_if.master     dsq,
    output logic         busy,
    output logic         acc_ovf,
    output logic         timeout_err
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    dsq_state_e       r_state;
    dsq_op_e          r_op;
    logic [CNT_W-1:0] r_tmo_cnt;
    logic [ACC_W-1:0] r_acc;
    logic             r_acc_ovf;
    logic             r_tmo_err;
    logic             r_dsq_valid;
    logic [31:0]      r_dsq_rs1;
    logic [31:0]      r_dsq_rs2;
    logic             r_ready;
    logic             r_wr;
    logic [31:0]      r_rd;

    logic             w_match;
    dsq_op_e          w_op;
    logic             w_use_dp;
    logic [ACC_W:0]   w_sum;

    dsq_insn_decode #(.OPC(OPC), .FUNCT7(FUNCT7)) u_dec (
        .i_valid  (pcpi.pcpi_valid),
        .i_instr  (pcpi.pcpi_instr),
        .o_match  (w_match),
        .o_op     (w_op),
        .o_use_dp (w_use_dp)
    );

    // Carry-out of the accumulate feeds the sticky overflow flag.
    assign w_sum = {1'b0, r_acc} + {1'b0, dsq.dsq_rd[ACC_W-1:0]};

    assign pcpi.pcpi_wait  = w_match && (r_state == S_IDLE || r_state == S_ISSUE);
    assign pcpi.pcpi_ready = r_ready;
    assign pcpi.pcpi_wr    = r_wr;
    assign pcpi.pcpi_rd    = r_rd;
    assign dsq.dsq_valid   = r_dsq_valid;
    assign dsq.dsq_rs1     = r_dsq_rs1;
    assign dsq.dsq_rs2     = r_dsq_rs2;
    assign busy            = (r_state != S_IDLE);
    assign acc_ovf         = r_acc_ovf;
    assign timeout_err     = r_tmo_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_op        <= F3_DSQ;
            r_tmo_cnt   <= '0;
            r_acc       <= '0;
            r_acc_ovf   <= 1'b0;
            r_tmo_err   <= 1'b0;
            r_dsq_valid <= 1'b0;
            r_dsq_rs1   <= '0;
            r_dsq_rs2   <= '0;
            r_ready     <= 1'b0;
            r_wr        <= 1'b0;
            r_rd        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_match && w_use_dp) begin
                        r_state     <= S_ISSUE;
                        r_op        <= w_op;
                        r_tmo_cnt   <= '0;
                        r_dsq_valid <= 1'b1;
                        r_dsq_rs1   <= pcpi.pcpi_rs1;
                        r_dsq_rs2   <= (w_op == F3_DSQ) ? pcpi.pcpi_rs2 : '0;
                    end else if (w_match) begin
                        r_state <= S_RESP;
                        r_ready <= 1'b1;
                        r_wr    <= 1'b1;
                        case (w_op)
                            F3_ACC_CLR: begin
                                r_rd  <= 32'(r_acc);
                                r_acc <= '0;
                            end
                            F3_ACC_WR: begin
                                r_rd  <= pcpi.pcpi_rs1;
                                r_acc <= ACC_W'(pcpi.pcpi_rs1);
                            end
                            default: r_rd <= 32'(r_acc);
                        endcase
                    end
                end
                S_ISSUE: begin
                    if (!pcpi.pcpi_valid) begin
                        // Core withdrew: abandon quietly, accumulator untouched.
                        r_state     <= S_IDLE;
                        r_dsq_valid <= 1'b0;
                        r_dsq_rs1   <= '0;
                        r_dsq_rs2   <= '0;
                    end else if (dsq.dsq_ready) begin
                        r_state     <= S_RESP;
                        r_dsq_valid <= 1'b0;
                        r_dsq_rs1   <= '0;
                        r_dsq_rs2   <= '0;
                        r_ready     <= 1'b1;
                        r_wr        <= 1'b1;
                        if (r_op == F3_DSQ_ACC) begin
                            r_acc <= w_sum[ACC_W-1:0];
                            r_rd  <= 32'(w_sum[ACC_W-1:0]);
                            if (w_sum[ACC_W]) r_acc_ovf <= 1'b1;
                        end else begin
                            r_rd <= dsq.dsq_rd;
                        end
                    end else if (r_tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_state     <= S_RESP;
                        r_dsq_valid <= 1'b0;
                        r_dsq_rs1   <= '0;
                        r_dsq_rs2   <= '0;
                        r_ready     <= 1'b1;
                        r_wr        <= 1'b0;
                        r_rd        <= '0;
                        r_tmo_err   <= 1'b1;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    r_state <= S_GUARD;
                    r_ready <= 1'b0;
                    r_wr    <= 1'b0;
                    r_rd    <= '0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dsq_pcpi_ctrl.sv
// Directed bench for dsq_pcpi_ctrl with a behavioural squared-difference responder.
module tb_dsq_pcpi_ctrl;
    logic clk = 1'b0;
    logic reset;
    logic busy, acc_ovf, timeout_err;
    logic dsq_en;
    int   n_chk = 0;
    int   n_err = 0;

    dsq_pcpi_if pcpi ();
    dsq_dp_if   dsq ();

    dsq_pcpi_ctrl #(.ACC_W(32), .TIMEOUT(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .pcpi        (pcpi),
        .dsq         (dsq),
        .busy        (busy),
        .acc_ovf     (acc_ovf),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dsq_model(input logic [31:0] a, input logic [31:0] b);
        int d1, d2;
        d1 = int'(a[31:24]) - int'(a[23:16]);
        d2 = int'(a[15:8]) - int'(a[7:0]);
        return 32'(d1 * d1 + d2 * d2) + b;
    endfunction

    // Single-cycle datapath: answers in the same cycle it sees valid.
    always_comb begin
        dsq.dsq_ready = dsq.dsq_valid && dsq_en;
        dsq.dsq_rd    = dsq_model(dsq.dsq_rs1, dsq.dsq_rs2);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_instr(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0001011};
    endfunction

    task automatic do_insn(input string tag, input logic [2:0] f3,
                           input logic [31:0] rs1, input logic [31:0] rs2,
                           output logic [31:0] rd, output logic wr, output int lat);
        logic got;
        got = 1'b0;
        lat = 0;
        rd  = '0;
        wr  = 1'b0;
        @(negedge clk);
        pcpi.pcpi_valid = 1'b1;
        pcpi.pcpi_instr = mk_instr(7'b0000001, f3);
        pcpi.pcpi_rs1   = rs1;
        pcpi.pcpi_rs2   = rs2;
        #1;
        chk({tag, "_wait"}, 32'(pcpi.pcpi_wait), 32'd1);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (pcpi.pcpi_ready) begin
                rd  = pcpi.pcpi_rd;
                wr  = pcpi.pcpi_wr;
                got = 1'b1;
                break;
            end
        end
        if (!got) chk({tag, "_no_ready"}, 32'd0, 32'd1);
        @(negedge clk);
        pcpi.pcpi_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] rs1,
                          input logic [31:0] rs2, input logic [31:0] exp_rd,
                          input logic exp_wr, input int exp_lat);
        logic [31:0] rd;
        logic        wr;
        int          lat;
        do_insn(tag, f3, rs1, rs2, rd, wr, lat);
        chk({tag, "_rd"}, rd, exp_rd);
        chk({tag, "_wr"}, 32'(wr), 32'(exp_wr));
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    // Holds an unclaimable instruction for 20 cycles; nothing may respond.
    task automatic no_claim(input string tag, input logic [31:0] instr);
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        pcpi.pcpi_valid = 1'b1;
        pcpi.pcpi_instr = instr;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (pcpi.pcpi_wait || pcpi.pcpi_ready || busy) seen = 1'b1;
            @(negedge clk);
        end
        chk(tag, 32'(seen), 32'd0);
        pcpi.pcpi_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        dsq_en = 1'b1;
        pcpi.pcpi_valid = 1'b0;
        pcpi.pcpi_instr = '0;
        pcpi.pcpi_rs1   = '0;
        pcpi.pcpi_rs2   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(pcpi.pcpi_ready), 32'd0);
        chk("rst_dsq_valid", 32'(dsq.dsq_valid), 32'd0);
        chk("rst_rd", pcpi.pcpi_rd, 32'd0);
        chk("rst_flags", {30'd0, acc_ovf, timeout_err}, 32'd0);

        // Plain DSQ, with and without addend
        run_op("dsq0", 3'b000, {8'd10, 8'd7, 8'd5, 8'd3}, 32'd0, 32'd13, 1'b1, 2);
        run_op("dsq_add", 3'b000, {8'd10, 8'd7, 8'd5, 8'd3}, 32'd5, 32'd18, 1'b1, 2);

        // Accumulate; nonzero rs2 must not reach the datapath
        run_op("acc1", 3'b001, {8'd10, 8'd8, 8'd6, 8'd4}, 32'h100, 32'd8, 1'b1, 2);
        run_op("acc2", 3'b001, {8'd3, 8'd1, 8'd9, 8'd6}, 32'h100, 32'd21, 1'b1, 2);
        run_op("accrd1", 3'b011, 32'd0, 32'd0, 32'd21, 1'b1, 1);
        run_op("accclr", 3'b010, 32'd0, 32'd0, 32'd21, 1'b1, 1);
        run_op("accrd2", 3'b011, 32'd0, 32'd0, 32'd0, 1'b1, 1);
        chk("no_ovf_yet", 32'(acc_ovf), 32'd0);

        // Wrap-around
        run_op("accwr", 3'b100, 32'hFFFF_FFFA, 32'd0, 32'hFFFF_FFFA, 1'b1, 1);
        run_op("acc_wrap", 3'b001, {8'd10, 8'd7, 8'd5, 8'd3}, 32'd0, 32'd7, 1'b1, 2);
        chk("acc_ovf", 32'(acc_ovf), 32'd1);

        // Datapath never answers: 16 ISSUE cycles then ready with wr=0
        dsq_en = 1'b0;
        chk("tmo_before", 32'(timeout_err), 32'd0);
        run_op("tmo", 3'b001, {8'd10, 8'd7, 8'd5, 8'd3}, 32'd0, 32'd0, 1'b0, 17);
        chk("tmo_err", 32'(timeout_err), 32'd1);
        dsq_en = 1'b1;
        run_op("tmo_accrd", 3'b011, 32'd0, 32'd0, 32'd7, 1'b1, 1);

        // Core withdraws mid-ISSUE
        dsq_en = 1'b0;
        @(negedge clk);
        pcpi.pcpi_valid = 1'b1;
        pcpi.pcpi_instr = mk_instr(7'b0000001, 3'b001);
        pcpi.pcpi_rs1   = 32'h0A07_0503;
        pcpi.pcpi_rs2   = 32'h55;
        repeat (3) @(negedge clk);
        chk("drop_dsq_valid", 32'(dsq.dsq_valid), 32'd1);
        chk("drop_dsq_rs1", dsq.dsq_rs1, 32'h0A07_0503);
        chk("drop_dsq_rs2", dsq.dsq_rs2, 32'd0);
        pcpi.pcpi_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("drop_dsq_valid_off", 32'(dsq.dsq_valid), 32'd0);
        chk("drop_busy", 32'(busy), 32'd0);
        chk("drop_dsq_rs1_off", dsq.dsq_rs1, 32'd0);
        begin
            logic rdy_seen;
            rdy_seen = 1'b0;
            for (int i = 0; i < 5; i++) begin
                @(posedge clk);
                #1;
                if (pcpi.pcpi_ready) rdy_seen = 1'b1;
            end
            chk("drop_no_ready", 32'(rdy_seen), 32'd0);
        end
        dsq_en = 1'b1;
        run_op("drop_accrd", 3'b011, 32'd0, 32'd0, 32'd7, 1'b1, 1);

        // Unclaimed encodings
        no_claim("bad_f7", mk_instr(7'b0000000, 3'b000));
        no_claim("bad_f3", mk_instr(7'b0000001, 3'b111));
        no_claim("bad_opc", {7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0101011});

        // Reset while in ISSUE
        dsq_en = 1'b0;
        @(negedge clk);
        pcpi.pcpi_valid = 1'b1;
        pcpi.pcpi_instr = mk_instr(7'b0000001, 3'b000);
        pcpi.pcpi_rs1   = 32'h0A07_0503;
        repeat (2) @(negedge clk);
        chk("rst_mid_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        pcpi.pcpi_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_dsq_valid", 32'(dsq.dsq_valid), 32'd0);
        chk("rst_mid_flags", {30'd0, acc_ovf, timeout_err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        dsq_en = 1'b1;
        run_op("rst_accrd", 3'b011, 32'd0, 32'd0, 32'd0, 1'b1, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

endmodule
